// File: rtl/key_filter_multi.sv
// ---------------------------------------------------------------------------
// key_filter_multi
//
// Debounces KEY_NUM mechanical keys independently. For each key it produces a
// debounced level, one-cycle press/release pulses, a press-toggled latch and a
// one-shot long-press pulse. All outputs are registered on sys_clk.
//
// Optional build macro: KEY_REPEAT_EN
//   When defined, a held key keeps generating key_press pulses (and toggling
//   key_toggle) every REPEAT_MAX cycles after key_long has fired.
//   When undefined, no repeat logic exists and REPEAT_MAX has no effect.
//
// Ports
//   sys_clk     in   1        system clock
//   sys_rst     in   1        synchronous active-high reset
//   key_in      in   KEY_NUM  raw asynchronous key pins
//   key_state   out  KEY_NUM  debounced level, 1 = pressed
//   key_press   out  KEY_NUM  one-cycle pulse on accepted press (and repeats)
//   key_release out  KEY_NUM  one-cycle pulse on accepted release
//   key_toggle  out  KEY_NUM  inverts on every key_press pulse
//   key_long    out  KEY_NUM  one-cycle pulse when a hold reaches LONG_MAX
// ---------------------------------------------------------------------------
module key_filter_multi #(
    parameter int KEY_NUM    = 4,
    parameter int CNT_MAX    = 399_999,
    parameter int CNT_W      = 20,
    parameter int LONG_MAX   = 9_999_999,
    parameter int LONG_W     = 24,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_MAX = 1_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_toggle,
    output logic [KEY_NUM-1:0] key_long
);

    // Pin level of an untouched key; the synchronisers start here so that a
    // key held through reset still has to pass a full debounce window.
    localparam logic [KEY_NUM-1:0] RELEASED_PIN = {KEY_NUM{ACTIVE_LOW != 0}};
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(CNT_MAX);
    localparam logic [LONG_W-1:0]  LONG_LAST    = LONG_W'(LONG_MAX);
    localparam logic [LONG_W-1:0]  LONG_PRE     = LONG_W'(LONG_MAX - 1);

    // Reject parameter sets whose limits do not fit the counters.
    generate
        if (longint'(CNT_MAX) >= (longint'(1) << CNT_W) ||
            longint'(LONG_MAX) >= (longint'(1) << LONG_W) ||
            longint'(REPEAT_MAX) >= (longint'(1) << LONG_W) ||
            CNT_MAX < 0 || LONG_MAX < 1 || REPEAT_MAX < 1) begin : g_bad_params
            $error("key_filter_multi: counter limits do not fit their widths");
        end
    endgenerate

    logic [KEY_NUM-1:0] r_sync1;
    logic [KEY_NUM-1:0] r_sync2;
    logic [CNT_W-1:0]   r_debCnt  [KEY_NUM];
    logic [LONG_W-1:0]  r_holdCnt [KEY_NUM];

    logic [KEY_NUM-1:0] w_level;
    logic [KEY_NUM-1:0] w_diff;
    logic [KEY_NUM-1:0] w_flip;
    logic [KEY_NUM-1:0] w_rise;
    logic [KEY_NUM-1:0] w_fall;
    logic [KEY_NUM-1:0] w_longHit;
    logic [KEY_NUM-1:0] w_repeat;

    // Two-flop synchroniser on every raw pin. Reset parks it at the released
    // pin level rather than zero so an active-low board does not see a
    // phantom press coming out of reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= RELEASED_PIN;
            r_sync2 <= RELEASED_PIN;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key decisions for this cycle. A flip happens when the normalised
    // level has disagreed with key_state for CNT_MAX+1 consecutive edges,
    // i.e. the counter already sits at CNT_MAX and the levels still differ.
    // key_long is decoded one count early so the registered pulse lands in
    // the cycle the hold counter reaches LONG_MAX.
    always_comb begin
        w_level   = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
        w_diff    = w_level ^ key_state;
        w_flip    = '0;
        w_longHit = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            w_flip[k]    = w_diff[k] && (r_debCnt[k] == CNT_LAST);
            w_longHit[k] = key_state[k] && (r_holdCnt[k] == LONG_PRE);
        end
        w_rise = w_flip & ~key_state;
        w_fall = w_flip & key_state;
    end

`ifdef KEY_REPEAT_EN
    localparam logic [LONG_W-1:0] RPT_PRE = LONG_W'(REPEAT_MAX - 1);

    logic [LONG_W-1:0] r_rptCnt [KEY_NUM];

    // Auto-repeat: once the hold counter has saturated (key_long has fired)
    // a second counter free-runs with period REPEAT_MAX. A repeat that falls
    // due on the same edge as an accepted release is suppressed.
    always_comb begin
        w_repeat = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            w_repeat[k] = key_state[k] && !w_fall[k] &&
                          (r_holdCnt[k] == LONG_LAST) &&
                          (r_rptCnt[k] == RPT_PRE);
        end
    end

    // Repeat period counter; idle at zero until the hold saturates.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < KEY_NUM; k++) begin
            if (sys_rst || !key_state[k] || (r_holdCnt[k] != LONG_LAST)) begin
                r_rptCnt[k] <= '0;
            end else if (r_rptCnt[k] == RPT_PRE) begin
                r_rptCnt[k] <= '0;
            end else begin
                r_rptCnt[k] <= r_rptCnt[k] + LONG_W'(1);
            end
        end
    end
`else
    // Without auto-repeat a held key produces exactly one press pulse.
    always_comb begin
        w_repeat = '0;
    end
`endif

    // Debounce counters and all registered outputs. The counter restarts
    // whenever the input agrees with the accepted level, so any bounce
    // shorter than the window throws away all progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_toggle  <= '0;
            key_long    <= '0;
            for (int k = 0; k < KEY_NUM; k++) begin
                r_debCnt[k] <= '0;
            end
        end else begin
            key_state   <= key_state ^ w_flip;
            key_press   <= w_rise | w_repeat;
            key_release <= w_fall;
            key_toggle  <= key_toggle ^ (w_rise | w_repeat);
            key_long    <= w_longHit;
            for (int k = 0; k < KEY_NUM; k++) begin
                if (!w_diff[k] || w_flip[k]) begin
                    r_debCnt[k] <= '0;
                end else begin
                    r_debCnt[k] <= r_debCnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Hold counters: zero while released, count up while pressed and stick at
    // LONG_MAX so key_long cannot fire twice in one press.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < KEY_NUM; k++) begin
            if (sys_rst || !key_state[k]) begin
                r_holdCnt[k] <= '0;
            end else if (r_holdCnt[k] != LONG_LAST) begin
                r_holdCnt[k] <= r_holdCnt[k] + LONG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// ---------------------------------------------------------------------------
// tb_key_filter_multi
//
// Drives directed key scenarios followed by random key patterns into a
// two-channel key_filter_multi and compares every output, every cycle,
// against a behavioural model built from run lengths and hold ages.
// Works with or without KEY_REPEAT_EN defined.
// ---------------------------------------------------------------------------
module tb_key_filter_multi;

    localparam int KN = 2;
    localparam int CM = 7;
    localparam int LM = 40;
    localparam int RM = 10;
    localparam int AL = 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [KN-1:0] key_in  = '1;
    logic [KN-1:0] key_state;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_toggle;
    logic [KN-1:0] key_long;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state: pipeline of pressed/not-pressed samples, the
    // length of the current disagreeing run, and the age of the current hold.
    bit      mP1   [KN];
    bit      mP2   [KN];
    bit      mState[KN];
    bit      mTog  [KN];
    int      mRun  [KN];
    int      mAge  [KN];
    bit [KN-1:0] eState, ePress, eRelease, eToggle, eLong;

    always #5 sys_clk = ~sys_clk;

    key_filter_multi #(
        .KEY_NUM   (KN),
        .CNT_MAX   (CM),
        .CNT_W     (20),
        .LONG_MAX  (LM),
        .LONG_W    (24),
        .ACTIVE_LOW(AL),
        .REPEAT_MAX(RM)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle),
        .key_long   (key_long)
    );

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    // A key is accepted once its sampled level has disagreed with the
    // accepted level for CNT_MAX+1 edges; the sample seen at an edge is the
    // pin value from two edges earlier.
    task automatic modelEdge();
        for (int c = 0; c < KN; c++) begin
            bit nowPressed, lvl, prev, rose, fell, rep;
            nowPressed = (AL != 0) ? !key_in[c] : key_in[c];
            if (sys_rst) begin
                mP1[c] = 0; mP2[c] = 0; mState[c] = 0; mTog[c] = 0;
                mRun[c] = 0; mAge[c] = 0;
                ePress[c] = 0; eRelease[c] = 0; eLong[c] = 0;
            end else begin
                lvl = mP2[c];
                mP2[c] = mP1[c];
                mP1[c] = nowPressed;
                prev = mState[c];
                rose = 0;
                fell = 0;
                if (lvl != mState[c]) begin
                    mRun[c]++;
                    if (mRun[c] == CM + 1) begin
                        mState[c] = !mState[c];
                        mRun[c] = 0;
                        rose = mState[c];
                        fell = !mState[c];
                    end
                end else begin
                    mRun[c] = 0;
                end
                mAge[c] = prev ? mAge[c] + 1 : 0;
                eLong[c] = prev && (mAge[c] == LM);
                rep = 0;
`ifdef KEY_REPEAT_EN
                rep = prev && !fell && (mAge[c] > LM) && ((mAge[c] - LM) % RM == 0);
`endif
                ePress[c] = rose || rep;
                eRelease[c] = fell;
                if (ePress[c]) mTog[c] = !mTog[c];
            end
            eState[c]  = mState[c];
            eToggle[c] = mTog[c];
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        modelEdge();
        checkOutput("model_state",   key_state,   eState);
        checkOutput("model_press",   key_press,   ePress);
        checkOutput("model_release", key_release, eRelease);
        checkOutput("model_toggle",  key_toggle,  eToggle);
        checkOutput("model_long",    key_long,    eLong);
    endtask

    task automatic applyStimulus(input logic [KN-1:0] keys, input logic rst,
                                 input int n);
        key_in  = keys;
        sys_rst = rst;
        repeat (n) tick();
    endtask

    initial begin
        int longFirst, longCount, pressCount, relAt;

        $display("[TB] start");

        // Reset with both keys released.
        applyStimulus(2'b11, 1'b1, 3);
        checkOutput("reset_state",  key_state,  2'b00);
        checkOutput("reset_toggle", key_toggle, 2'b00);
        checkOutput("reset_long",   key_long,   2'b00);
        applyStimulus(2'b11, 1'b0, 2);

        // Clean press on channel 0: pulse exactly 10 edges after the drive.
        applyStimulus(2'b10, 1'b0, 9);
        checkOutput("press_early", key_press, 2'b00);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("press_edge",  key_press,  2'b01);
        checkOutput("press_state", key_state,  2'b01);
        checkOutput("press_tog",   key_toggle, 2'b01);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("press_width", key_press, 2'b00);

        // Long hold: key_long once, 40 edges after the rise; repeats if built.
        longFirst = -1; longCount = 0; pressCount = 0;
        for (int i = 2; i <= 100; i++) begin
            tick();
            if (key_long[0]) begin
                if (longFirst < 0) longFirst = i;
                longCount++;
            end
            if (key_press[0]) pressCount++;
        end
        checkOutput("long_at",    longFirst, LM);
        checkOutput("long_count", longCount, 1);
`ifdef KEY_REPEAT_EN
        checkOutput("repeat_count", pressCount, (100 - LM) / RM);
`else
        checkOutput("repeat_count", pressCount, 0);
`endif

        // Release: the repeat due on the release edge must be suppressed.
        key_in = 2'b11;
        relAt = -1; pressCount = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_release[0] && relAt < 0) relAt = i;
            if (key_press[0]) pressCount++;
        end
        checkOutput("release_at",     relAt, 10);
        checkOutput("release_press",  pressCount, 0);
        checkOutput("release_toggle", key_toggle, 2'b01);

        // Bounce: four short low bursts are rejected.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(2'b10, 1'b0, 5);
            applyStimulus(2'b11, 1'b0, 1);
        end
        checkOutput("bounce_state",  key_state,  2'b00);
        checkOutput("bounce_toggle", key_toggle, 2'b01);
        applyStimulus(2'b10, 1'b0, 9);
        checkOutput("bounce_early", key_state, 2'b00);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("second_press", key_press,  2'b01);
        checkOutput("second_tog",   key_toggle, 2'b00);

        // Short hold then release: no key_long.
        applyStimulus(2'b10, 1'b0, 5);
        applyStimulus(2'b11, 1'b0, 12);
        checkOutput("short_hold_state", key_state, 2'b00);

        // Press channel 1, then swap: press 0 and release 1 together.
        applyStimulus(2'b01, 1'b0, 12);
        applyStimulus(2'b10, 1'b0, 9);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("simul_press",   key_press,   2'b01);
        checkOutput("simul_release", key_release, 2'b10);
        applyStimulus(2'b11, 1'b0, 12);

        // Reset mid-debounce with channel 0 held.
        applyStimulus(2'b10, 1'b0, 7);
        applyStimulus(2'b10, 1'b1, 1);
        checkOutput("midrst_state",  key_state,  2'b00);
        checkOutput("midrst_toggle", key_toggle, 2'b00);
        checkOutput("midrst_press",  key_press,  2'b00);
        applyStimulus(2'b10, 1'b0, 9);
        checkOutput("midrst_early", key_state, 2'b00);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("midrst_press_after", key_press, 2'b01);

        // Random key patterns: mostly short segments, some long holds,
        // occasional reset.
        for (int s = 0; s < 200; s++) begin
            logic [KN-1:0] keys;
            logic          rst;
            int            len;
            keys = KN'($urandom_range(0, 3));
            rst  = ($urandom_range(0, 49) == 0);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 80)
                                                : $urandom_range(1, 12);
            applyStimulus(keys, rst, rst ? 1 : len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
